spi_write_queue: RTL

Command queue and sequencer between the command processor and the two PLL SPI masters (ADF4002, LMX2594). Accepts register-write requests on a valid/ready port, buffers them in a FIFO, and issues them one at a time to the selected `spi_master`. Each transfer completes through its start/ready handshake before the next begins. This lets the processor burst a whole PLL programming sequence (e.g. a full LMX2594 register map) without polling `spi_ready`.

---
 rtl/spi_write_queue_if.sv | 22 ++
 rtl/spi_write_queue.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_write_queue_if.sv
// Request port of the SPI write queue: one register write per valid/ready beat.
interface spi_write_queue_if #(
  parameter int DATA_W = 54
);
  logic              wr_valid;
  logic              wr_ready;
  logic              wr_target;
  logic [7:0]        wr_depth;
  logic [DATA_W-1:0] wr_data;

  // Command processor side
  modport master (
    output wr_valid, wr_target, wr_depth, wr_data,
    input  wr_ready
  );

  // Queue side
  modport slave (
    input  wr_valid, wr_target, wr_depth, wr_data,
    output wr_ready
  );
endinterface

// File: rtl/spi_write_queue.sv
// SPI write queue: buffers register writes for the two PLL SPI masters and
// issues them one at a time, each through a full start/ready handshake
// followed by a fixed idle gap.
module spi_write_queue #(
  parameter int   DATA_W      = 54,
  parameter int   ADDR_W      = 4,
  parameter logic SPI_DIR     = 1'b1,
  parameter int   ACK_TIMEOUT = 16,
  parameter int   GAP_CYCLES  = 4
) (
  input  logic                clk,
  input  logic                rst,
  spi_write_queue_if.slave    wr,
  input  logic [1:0]          spi_ready,
  output logic [1:0]          spi_start,
  output logic                spi_dir,
  output logic [7:0]          spi_data_depth,
  output logic [DATA_W-1:0]   spi_data_tx,
  output logic [ADDR_W:0]     level,
  output logic                busy,
  output logic                done,
  output logic                err_depth,
  output logic                err_timeout,
  input  logic                clr_err
);

  localparam int DEPTH   = 2**ADDR_W;
  localparam int ENTRY_W = 1 + 8 + DATA_W;
  localparam int TO_W    = $clog2(ACK_TIMEOUT + 1);
  localparam int GAP_W   = $clog2(GAP_CYCLES + 1);

  localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_ACK,
    WAIT_DONE,
    GAP
  } state_t;

  // Entry layout: {target, depth, data}
  logic [ENTRY_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   level_reg;
  logic [ADDR_W:0]   level_next;
  logic              wr_ready_reg;

  state_t            state_reg;
  logic              tgt_reg;
  logic [7:0]        depth_reg;
  logic [DATA_W-1:0] data_reg;
  logic [1:0]        spi_start_reg;
  logic              done_reg;
  logic              busy_reg;
  logic [TO_W-1:0]   to_cnt_reg;
  logic [GAP_W-1:0]  gap_cnt_reg;
  logic              err_depth_reg;
  logic              err_timeout_reg;

  logic wr_fire;
  logic depth_ok;
  logic push;
  logic bad_req;
  logic pop;
  logic timeout_evt;
  logic gap_done;
  logic fsm_to_idle;

  // Request qualification, FIFO occupancy update and FSM next-idle decode
  always_comb begin
    wr_fire     = wr.wr_valid && wr_ready_reg;
    depth_ok    = (wr.wr_depth != 8'd0) && (wr.wr_depth <= 8'(DATA_W));
    push        = wr_fire && depth_ok;
    bad_req     = wr_fire && !depth_ok;
    pop         = (state_reg == IDLE) && (level_reg != '0);
    timeout_evt = (state_reg == WAIT_ACK) && spi_ready[tgt_reg] && (to_cnt_reg == TO_LAST);
    gap_done    = (gap_cnt_reg == GAP_LAST);
    fsm_to_idle = ((state_reg == IDLE) && !pop) || ((state_reg == GAP) && gap_done);

    level_next = level_reg;
    if (push && !pop) begin
      level_next = level_reg + LVL_ONE;
    end else if (pop && !push) begin
      level_next = level_reg - LVL_ONE;
    end
  end

  // FIFO pointers, occupancy and registered ready (ready reflects the
  // post-update level, so a pop never frees a slot in the same cycle)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      wr_ready_reg <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      level_reg    <= level_next;
      wr_ready_reg <= (level_next != LVL_FULL);
    end
  end

  // Queue storage; no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {wr.wr_target, wr.wr_depth, wr.wr_data};
    end
  end

  // Transfer sequencer: pop, start pulse, wait for ack, wait for idle, gap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      tgt_reg       <= 1'b0;
      depth_reg     <= '0;
      data_reg      <= '0;
      spi_start_reg <= 2'b00;
      done_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      to_cnt_reg    <= '0;
      gap_cnt_reg   <= '0;
    end else begin
      spi_start_reg <= 2'b00;
      done_reg      <= 1'b0;
      busy_reg      <= !fsm_to_idle || (level_next != '0);
      case (state_reg)
        IDLE: begin
          if (pop) begin
            {tgt_reg, depth_reg, data_reg} <= mem[rd_ptr_reg];
            state_reg <= START;
          end
        end
        START: begin
          spi_start_reg[tgt_reg] <= 1'b1;
          to_cnt_reg             <= '0;
          state_reg              <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (!spi_ready[tgt_reg]) begin
            state_reg <= WAIT_DONE;
          end else if (timeout_evt) begin
            done_reg    <= 1'b1;
            gap_cnt_reg <= '0;
            state_reg   <= GAP;
          end else begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
          end
        end
        WAIT_DONE: begin
          if (spi_ready[tgt_reg]) begin
            done_reg    <= 1'b1;
            gap_cnt_reg <= '0;
            state_reg   <= GAP;
          end
        end
        GAP: begin
          if (gap_done) begin
            state_reg <= IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Sticky error flags; a new error event overrides a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_depth_reg   <= 1'b0;
      err_timeout_reg <= 1'b0;
    end else begin
      if (bad_req) begin
        err_depth_reg <= 1'b1;
      end else if (clr_err) begin
        err_depth_reg <= 1'b0;
      end
      if (timeout_evt) begin
        err_timeout_reg <= 1'b1;
      end else if (clr_err) begin
        err_timeout_reg <= 1'b0;
      end
    end
  end

  assign wr.wr_ready     = wr_ready_reg;
  assign spi_start       = spi_start_reg;
  assign spi_dir         = SPI_DIR;
  assign spi_data_depth  = depth_reg;
  assign spi_data_tx     = data_reg;
  assign level           = level_reg;
  assign busy            = busy_reg;
  assign done            = done_reg;
  assign err_depth       = err_depth_reg;
  assign err_timeout     = err_timeout_reg;

endmodule
